mod_mul_serial: RTL and testbench



---
 rtl/mod_mul_serial.sv | 128 ++++++++++++
 tb/tb_mod_mul_serial.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mod_mul_serial.sv
// ============================================================================
//  Module      : mod_mul_serial
//  Description : Bit-serial modular multiplier, r = (a*b) mod p, one
//                multiplier bit per clock with interleaved shift-add-reduce.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul_serial #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] r
);

    localparam int               c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_TWO      = WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     p_q;
    logic [WIDTH-1:0]     acc_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic                 err_pend_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [WIDTH-1:0]     r_q;

    logic                 w_reject;
    logic [WIDTH:0]       w_p_ext;
    logic [WIDTH:0]       w_t_shift;
    logic [WIDTH-1:0]     w_t_red1;
    logic [WIDTH:0]       w_t_add;
    logic [WIDTH-1:0]     acc_d;

    // Operand screening is done on the live inputs at the accepting edge.
    assign w_reject = (p < c_TWO) || (a >= p) || (b >= p);

    // acc < p on entry, so each intermediate stays below 2p and fits WIDTH+1 bits.
    always_comb begin
        w_p_ext   = {1'b0, p_q};
        w_t_shift = {acc_q, 1'b0};
        w_t_red1  = WIDTH'((w_t_shift >= w_p_ext) ? (w_t_shift - w_p_ext) : w_t_shift);
        w_t_add   = a_q[cnt_q] ? ({1'b0, w_t_red1} + {1'b0, b_q}) : {1'b0, w_t_red1};
        acc_d     = WIDTH'((w_t_add >= w_p_ext) ? (w_t_add - w_p_ext) : w_t_add);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            r_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        p_q    <= p;
                        acc_q  <= '0;
                        cnt_q  <= c_CNT_INIT;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (w_reject) begin
                            err_pend_q <= 1'b1;
                            state_q    <= S_FIN;
                        end else begin
                            err_pend_q <= 1'b0;
                            state_q    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_FIN: begin
                    r_q     <= err_pend_q ? '0 : acc_q;
                    err_q   <= err_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign r    = r_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_mul_serial.sv
// ============================================================================
//  Module      : tb_mod_mul_serial
//  Description : Directed self-checking bench for mod_mul_serial.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_mul_serial;

    localparam int W = 256;
    localparam logic [W-1:0] c_SECP =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] r;

    int checks = 0;
    int errors = 0;

    mod_mul_serial #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, scrambles the inputs afterwards, waits (bounded) for done.
    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ip, input int exp_lat, input logic exp_err,
                          input logic [W-1:0] exp_r);
        int n;
        bit busy_ok;
        a = ia; b = ib; p = ip; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; p = ~ip;
        chk({tag, "_accept_busy_done"}, W'({busy, done}), W'(2'b10));
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 400) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            n++;
        end
        chk({tag, "_latency"}, W'(n), W'(exp_lat));
        chk({tag, "_busy_held"}, W'(busy_ok), W'(1));
        chk({tag, "_err"}, W'(err), W'(exp_err));
        chk({tag, "_r"}, r, exp_r);
        chk({tag, "_busy_low"}, W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] half;
        int  n;
        bit  seen_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; p = '0;
        repeat (3) tick();
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_err",  W'(err),  W'(0));
        chk("rst_r",    r,        '0);
        rst = 1'b0;
        tick();

        run_op("small", 256'd7, 256'd5, 256'd11, 257, 1'b0, 256'd2);
        repeat (5) tick();
        chk("small_hold_done", W'(done), W'(1));
        chk("small_hold_r", r, 256'd2);

        run_op("maxop", 256'd10, 256'd10, 256'd11, 257, 1'b0, 256'd1);

        half = (c_SECP + 256'd1) >> 1;
        run_op("secp_m1sq", c_SECP - 256'd1, c_SECP - 256'd1, c_SECP, 257, 1'b0, 256'd1);
        run_op("secp_inv2", 256'd2, half, c_SECP, 257, 1'b0, 256'd1);
        run_op("secp_zero", 256'd0, c_SECP - 256'd1, c_SECP, 257, 1'b0, 256'd0);
        run_op("secp_one", 256'd1, 256'h1234, c_SECP, 257, 1'b0, 256'h1234);

        run_op("rej_a_eq_p", 256'd11, 256'd3, 256'd11, 1, 1'b1, 256'd0);
        run_op("rej_b_eq_p", 256'd3, 256'd11, 256'd11, 1, 1'b1, 256'd0);
        run_op("rej_p1", 256'd0, 256'd0, 256'd1, 1, 1'b1, 256'd0);
        run_op("rej_p0", 256'd0, 256'd0, 256'd0, 1, 1'b1, 256'd0);

        // Start re-pulsed mid-run with different operands must be ignored.
        a = 256'd7; b = 256'd5; p = 256'd11; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
            if (n == 10 || n == 256) begin
                a = 256'd3; b = 256'd4; p = 256'd13; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("repulse_latency", W'(n), W'(257));
        chk("repulse_r", r, 256'd2);
        repeat (4) tick();
        chk("repulse_single_done", W'({busy, done}), W'(2'b01));
        chk("repulse_r_stable", r, 256'd2);

        // Reset mid-run abandons the operation.
        a = 256'd7; b = 256'd5; p = 256'd11; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_err",  W'(err),  W'(0));
        chk("midrst_r",    r,        '0);
        seen_done = 1'b0;
        repeat (300) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        chk("midrst_no_done", W'(seen_done), W'(0));
        run_op("after_rst", 256'd7, 256'd5, 256'd11, 257, 1'b0, 256'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
